grouped_merge_bank: RTL and testbench

Parametrised register bank whose bits are partitioned into equal groups. Each cycle the bank loads new data, broadcasts each group's leader bit across its group, or holds, all under one merged update condition. It is the next generation of the fixed 16-bit force-merge bank. It adds configurable width and group size, selectable leader position, an exported clock-gate enable vector, a saturating activity counter and an update strobe. It sits in front of datapath consumers that need one shared clock gate per bank for low-power flows.

---
 rtl/grouped_merge_bank_if.sv | 20 ++
 rtl/grouped_merge_bank.sv | 76 +++++++
 tb/tb_grouped_merge_bank.sv | 125 ++++++++++++
 3 files changed

// File: rtl/grouped_merge_bank_if.sv
// Handshake/data bundle for grouped_merge_bank: load/hold requests, counter clear,
// bank contents, clock-gate enables and activity outputs.
interface grouped_merge_bank_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             valid;
  logic             last;
  logic             cnt_clr;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic [1:0]       cg_en;
  logic             upd;
  logic [CNT_W-1:0] act_cnt;

  modport master (output valid, last, cnt_clr, in,
                  input  out, cg_en, upd, act_cnt);
  modport slave  (input  valid, last, cnt_clr, in,
                  output out, cg_en, upd, act_cnt);
endinterface

// File: rtl/grouped_merge_bank.sv
// Grouped register bank: load, per-group leader broadcast or hold under one merged enable.
// Build option GROUPED_MERGE_FORCE_SENA_EN: leader gate enable follows the merged enable.

module grouped_merge_grp #(
  parameter int GRP_W = 4,
  parameter int LIDX  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             men,
  input  logic [GRP_W-1:0] d,
  output logic [GRP_W-1:0] q
);
  // Broadcast reads the pre-edge leader, so there is no chaining between groups.
  always_ff @(posedge clk) begin
    if (rst)        q <= '0;
    else if (valid) q <= d;
    else if (men)   q <= {GRP_W{q[LIDX]}};
  end
endmodule

module grouped_merge_bank #(
  parameter int WIDTH      = 16,
  parameter int GRP_W      = 4,
  parameter bit LEADER_MSB = 1'b1,
  parameter int CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  grouped_merge_bank_if.slave bus
);
  localparam int GROUPS = WIDTH / GRP_W;
  localparam int LIDX   = LEADER_MSB ? GRP_W - 1 : 0;

  if (WIDTH % GRP_W != 0) begin : g_bad_cfg
    $error("grouped_merge_bank: WIDTH must be a multiple of GRP_W");
  end

  logic                          men;
  logic [GROUPS-1:0][GRP_W-1:0]  din;
  logic [GROUPS-1:0][GRP_W-1:0]  q;
  logic                          upd_q;
  logic [CNT_W-1:0]              cnt_q;

  assign men = bus.valid | ~bus.last;
  assign din = bus.in;

  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    grouped_merge_grp #(.GRP_W(GRP_W), .LIDX(LIDX)) u_grp (
      .clk   (clk),
      .rst   (rst),
      .valid (bus.valid),
      .men   (men),
      .d     (din[g]),
      .q     (q[g])
    );
  end

  always_ff @(posedge clk) begin
    upd_q <= men & ~rst;
    if (rst || bus.cnt_clr)         cnt_q <= '0;
    else if (men && cnt_q != '1)    cnt_q <= cnt_q + 1'b1;
  end

`ifdef GROUPED_MERGE_FORCE_SENA_EN
  // One shared condition lets synthesis build a single gate for the whole bank.
  assign bus.cg_en = rst ? 2'b00 : {men, men};
`else
  assign bus.cg_en = rst ? 2'b00 : {men, bus.valid};
`endif

  assign bus.out     = q;
  assign bus.upd     = upd_q;
  assign bus.act_cnt = cnt_q;
endmodule

// File: tb/tb_grouped_merge_bank.sv
// Directed bench for grouped_merge_bank: MSB-leader, LSB-leader and 2-bit-counter
// instances share one stimulus stream.
module tb_grouped_merge_bank;
  logic        clk = 1'b0;
  logic        rst, valid, last, cnt_clr;
  logic [15:0] din;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [1:0]  cg_bcast;

  always #5 clk = ~clk;

  grouped_merge_bank_if #(.WIDTH(16), .CNT_W(8)) b_msb ();
  grouped_merge_bank_if #(.WIDTH(16), .CNT_W(8)) b_lsb ();
  grouped_merge_bank_if #(.WIDTH(16), .CNT_W(2)) b_c2 ();

  assign b_msb.valid = valid; assign b_msb.last = last; assign b_msb.cnt_clr = cnt_clr; assign b_msb.in = din;
  assign b_lsb.valid = valid; assign b_lsb.last = last; assign b_lsb.cnt_clr = cnt_clr; assign b_lsb.in = din;
  assign b_c2.valid  = valid; assign b_c2.last  = last; assign b_c2.cnt_clr  = cnt_clr; assign b_c2.in  = din;

  grouped_merge_bank #(.WIDTH(16), .GRP_W(4), .LEADER_MSB(1'b1), .CNT_W(8)) dut_msb (.clk(clk), .rst(rst), .bus(b_msb));
  grouped_merge_bank #(.WIDTH(16), .GRP_W(4), .LEADER_MSB(1'b0), .CNT_W(8)) dut_lsb (.clk(clk), .rst(rst), .bus(b_lsb));
  grouped_merge_bank #(.WIDTH(16), .GRP_W(4), .LEADER_MSB(1'b1), .CNT_W(2)) dut_c2  (.clk(clk), .rst(rst), .bus(b_c2));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b1; last = 1'b0; cnt_clr = 1'b0; din = 16'hFFFF;
    step(); step();
    n_chk++; if (b_msb.out !== 16'h0) begin n_fail++; $display("FAIL reset_out got %h exp 0000", b_msb.out); end
    n_chk++; if (b_lsb.out !== 16'h0) begin n_fail++; $display("FAIL reset_out_lsb got %h exp 0000", b_lsb.out); end
    n_chk++; if (b_msb.upd !== 1'b0) begin n_fail++; $display("FAIL reset_upd got %b exp 0", b_msb.upd); end
    n_chk++; if (b_msb.act_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", b_msb.act_cnt); end
    n_chk++; if (b_msb.cg_en !== 2'b00) begin n_fail++; $display("FAIL reset_cg got %b exp 00", b_msb.cg_en); end
  endtask

  task automatic test_load();
    rst = 1'b0; valid = 1'b1; last = 1'b0; din = 16'h8421;
    step();
    valid = 1'b0; last = 1'b1;
    n_chk++; if (b_msb.out !== 16'h8421) begin n_fail++; $display("FAIL load_out got %h exp 8421", b_msb.out); end
    n_chk++; if (b_lsb.out !== 16'h8421) begin n_fail++; $display("FAIL load_out_lsb got %h exp 8421", b_lsb.out); end
    n_chk++; if (b_msb.upd !== 1'b1) begin n_fail++; $display("FAIL load_upd got %b exp 1", b_msb.upd); end
    n_chk++; if (b_msb.act_cnt !== 8'd1) begin n_fail++; $display("FAIL load_cnt got %0d exp 1", b_msb.act_cnt); end
  endtask

  task automatic test_broadcast();
    valid = 1'b0; last = 1'b0; #1;
    n_chk++; if (b_msb.cg_en !== cg_bcast) begin n_fail++; $display("FAIL bcast_cg got %b exp %b", b_msb.cg_en, cg_bcast); end
    step();
    last = 1'b1;
    // 8421 leaders: MSBs 1,0,0,0 -> F000; LSBs 0,0,0,1 -> 000F
    n_chk++; if (b_msb.out !== 16'hF000) begin n_fail++; $display("FAIL bcast_msb got %h exp F000", b_msb.out); end
    n_chk++; if (b_lsb.out !== 16'h000F) begin n_fail++; $display("FAIL bcast_lsb got %h exp 000F", b_lsb.out); end
    n_chk++; if (b_msb.upd !== 1'b1) begin n_fail++; $display("FAIL bcast_upd got %b exp 1", b_msb.upd); end
    n_chk++; if (b_msb.act_cnt !== 8'd2) begin n_fail++; $display("FAIL bcast_cnt got %0d exp 2", b_msb.act_cnt); end
  endtask

  task automatic test_hold();
    valid = 1'b0; last = 1'b1; #1;
    n_chk++; if (b_msb.cg_en !== 2'b00) begin n_fail++; $display("FAIL hold_cg got %b exp 00", b_msb.cg_en); end
    for (int i = 0; i < 5; i++) begin
      step();
      n_chk++; if (b_msb.out !== 16'hF000 || b_lsb.out !== 16'h000F) begin
        n_fail++; $display("FAIL hold_out[%0d] got %h/%h exp F000/000F", i, b_msb.out, b_lsb.out); end
      n_chk++; if (b_msb.upd !== 1'b0) begin n_fail++; $display("FAIL hold_upd[%0d] got %b exp 0", i, b_msb.upd); end
      n_chk++; if (b_msb.act_cnt !== 8'd2) begin n_fail++; $display("FAIL hold_cnt[%0d] got %0d exp 2", i, b_msb.act_cnt); end
    end
  endtask

  task automatic test_counter();
    logic [1:0] exp_c2 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    valid = 1'b1; last = 1'b0; cnt_clr = 1'b1; din = 16'h1234;
    step();
    n_chk++; if (b_c2.act_cnt !== 2'd0 || b_msb.act_cnt !== 8'd0) begin
      n_fail++; $display("FAIL clr_vs_load got %0d/%0d exp 0/0", b_c2.act_cnt, b_msb.act_cnt); end
    n_chk++; if (b_msb.out !== 16'h1234) begin n_fail++; $display("FAIL clr_load_out got %h exp 1234", b_msb.out); end
    valid = 1'b0; cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_chk++; if (b_c2.act_cnt !== exp_c2[i]) begin n_fail++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", i, b_c2.act_cnt, exp_c2[i]); end
      n_chk++; if (b_msb.act_cnt !== 8'(i + 1)) begin n_fail++; $display("FAIL cnt8[%0d] got %0d exp %0d", i, b_msb.act_cnt, i + 1); end
    end
    rst = 1'b1; valid = 1'b1; cnt_clr = 1'b1; din = 16'hBEEF;
    step();
    n_chk++; if (b_c2.out !== 16'h0 || b_c2.upd !== 1'b0 || b_c2.act_cnt !== 2'd0 || b_c2.cg_en !== 2'b00) begin
      n_fail++; $display("FAIL rst_prio got out=%h upd=%b cnt=%0d cg=%b exp all 0", b_c2.out, b_c2.upd, b_c2.act_cnt, b_c2.cg_en); end
    rst = 1'b0; valid = 1'b0; last = 1'b1; cnt_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    valid = 1'b1; last = 1'b0; din = 16'hA5A5;
    step();
    n_chk++; if (b_msb.out !== 16'hA5A5) begin n_fail++; $display("FAIL b2b_load0 got %h exp A5A5", b_msb.out); end
    last = 1'b1; din = 16'h3C3C; #1;
    n_chk++; if (b_msb.cg_en !== 2'b11) begin n_fail++; $display("FAIL b2b_cg got %b exp 11", b_msb.cg_en); end
    step();
    n_chk++; if (b_msb.out !== 16'h3C3C) begin n_fail++; $display("FAIL b2b_load1 got %h exp 3C3C", b_msb.out); end
    valid = 1'b0; last = 1'b0;
    step();
    valid = 1'b0; last = 1'b1;
    n_chk++; if (b_msb.out !== 16'h0F0F) begin n_fail++; $display("FAIL b2b_bcast_msb got %h exp 0F0F", b_msb.out); end
    n_chk++; if (b_lsb.out !== 16'hF0F0) begin n_fail++; $display("FAIL b2b_bcast_lsb got %h exp F0F0", b_lsb.out); end
    n_chk++; if (b_msb.act_cnt !== 8'd3 || b_msb.upd !== 1'b1) begin
      n_fail++; $display("FAIL b2b_cnt got cnt=%0d upd=%b exp 3/1", b_msb.act_cnt, b_msb.upd); end
  endtask

  initial begin
`ifdef GROUPED_MERGE_FORCE_SENA_EN
    cg_bcast = 2'b11;
`else
    cg_bcast = 2'b10;
`endif
    test_reset();
    test_load();
    test_broadcast();
    test_hold();
    test_counter();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
